// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus strobe generators (read and write side).
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ASETUP = 3'd1,
        AWR    = 3'd2,
        GAP    = 3'd3,
        RDLOW  = 3'd4,
        HOLD   = 3'd5
    } rtcState_t;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int T_SETUP_DEF = 2;
    localparam int T_ADDR_DEF  = 6;
    localparam int T_GAP_DEF   = 2;
    localparam int T_READ_DEF  = 6;
    localparam int T_HOLD_DEF  = 2;
    localparam int CNT_W_DEF   = 4;

    typedef struct packed {
        logic cs;
        logic rd;
        logic wr;
        logic ad;
        logic oe;
    } rtcStrobes_t;

    // Pad-side levels for each state; bus_oe follows AD=0 by construction.
    function automatic rtcStrobes_t stateStrobes(input rtcState_t s);
        rtcStrobes_t o;
        o = '{cs: STROBE_OFF, rd: STROBE_OFF, wr: STROBE_OFF, ad: 1'b1, oe: 1'b0};
        case (s)
            ASETUP: o = '{cs: STROBE_ON, rd: STROBE_OFF, wr: STROBE_OFF, ad: 1'b0, oe: 1'b1};
            AWR:    o = '{cs: STROBE_ON, rd: STROBE_OFF, wr: STROBE_ON,  ad: 1'b0, oe: 1'b1};
            RDLOW:  o = '{cs: STROBE_ON, rd: STROBE_ON,  wr: STROBE_OFF, ad: 1'b1, oe: 1'b0};
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase counter: cleared on state entry, counts up, saturates, flags the last cycle of a phase.
module rtc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clkW,
    input  logic             resetW,
    input  logic             clr,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clkW or posedge resetW) begin
        if (resetW)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/rtc_read_timing.sv
// RTC read-cycle generator: address-write phase then data-read phase on the muxed bus.
// Optional RTC_BCD_CHECK_EN adds bcd_err, flagging a sampled byte with a nibble above 9.
module rtc_read_timing
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_ADDR  = T_ADDR_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_READ  = T_READ_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clkW,
    input  logic       resetW,
    input  logic       enR,
    input  logic [7:0] addr,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    output logic [7:0] data_out,
    output logic       data_valid,
`ifdef RTC_BCD_CHECK_EN
    output logic       bcd_err,
`endif
    output logic       busy
);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_ADDR  = CNT_W'(T_ADDR - 1);
    localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] L_READ  = CNT_W'(T_READ - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);

    rtcState_t        state, stateNext;
    logic [CNT_W-1:0] phaseLast;
    logic [CNT_W-1:0] phaseCnt;
    logic             phaseTc;
    logic             timerClr;
    logic             accept;
    logic             capture;
    rtcStrobes_t      strbNext;
    logic             busyNext;

    rtc_phase_timer #(.CNT_W(CNT_W)) phaseTimer (
        .clkW   (clkW),
        .resetW (resetW),
        .clr    (timerClr),
        .last   (phaseLast),
        .cnt    (phaseCnt),
        .tc     (phaseTc)
    );

    always_comb begin
        phaseLast = '0;
        case (state)
            ASETUP:  phaseLast = L_SETUP;
            AWR:     phaseLast = L_ADDR;
            GAP:     phaseLast = L_GAP;
            RDLOW:   phaseLast = L_READ;
            HOLD:    phaseLast = L_HOLD;
            default: phaseLast = '0;
        endcase
    end

    // State register
    always_ff @(posedge clkW or posedge resetW) begin
        if (resetW)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (enR)     stateNext = ASETUP;
            ASETUP:  if (phaseTc) stateNext = AWR;
            AWR:     if (phaseTc) stateNext = GAP;
            GAP:     if (phaseTc) stateNext = RDLOW;
            RDLOW:   if (phaseTc) stateNext = HOLD;
            HOLD:    if (phaseTc) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Keep the counter parked at zero in IDLE and restart it on every phase entry.
        timerClr = (stateNext != state) || (state == IDLE);
    end

    // Output logic: values the output registers take at the coming edge
    always_comb begin
        strbNext = stateStrobes(stateNext);
        busyNext = (stateNext != IDLE);
        accept   = (state == IDLE) && enR;
        capture  = (state == RDLOW) && phaseTc;
    end

    always_ff @(posedge clkW or posedge resetW) begin
        if (resetW) begin
            CS         <= STROBE_OFF;
            RD         <= STROBE_OFF;
            WR         <= STROBE_OFF;
            AD         <= 1'b1;
            bus_oe     <= 1'b0;
            bus_out    <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            CS         <= strbNext.cs;
            RD         <= strbNext.rd;
            WR         <= strbNext.wr;
            AD         <= strbNext.ad;
            bus_oe     <= strbNext.oe;
            busy       <= busyNext;
            data_valid <= capture;
            if (accept)
                bus_out <= addr;
            if (capture)
                data_out <= bus_in;
        end
    end

`ifdef RTC_BCD_CHECK_EN
    always_ff @(posedge clkW or posedge resetW) begin
        if (resetW)
            bcd_err <= 1'b0;
        else if (capture)
            bcd_err <= (bus_in[7:4] > 4'd9) || (bus_in[3:0] > 4'd9);
    end
`endif

endmodule
